demux_1_to_4: RTL and testbench

Registered 1-to-4 time-division demultiplexer: the receive-side counterpart of `mux_4_to_1`. It accepts one data beat per valid cycle on a single input and steers it into one of four held output lanes. The lane comes either from an explicit `SEL` (addressed mode) or from an internal wrapping pointer (round-robin mode). It also tracks frame completion across all four lanes and flags lane overwrites, so a stream serialized through `mux_4_to_1` can be reassembled.

---
 rtl/demux_pkg.sv | 23 ++
 rtl/lane_ptr.sv | 38 +++
 rtl/demux_1_to_4.sv | 109 ++++++++++
 tb/tb_demux_1_to_4.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-4 time-division demultiplexer.
//   NUM_LANES / SEL_W : lane count and lane-index width
//   MODE_ADDR/MODE_RR : MODE input encodings (addressed / round-robin)
//   FULL_MASK         : written-lane mask value that completes a frame
//   lane_onehot()     : lane index -> one-hot lane strobe
package demux_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned SEL_W     = 2;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    localparam logic [NUM_LANES-1:0] FULL_MASK = 4'b1111;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_LANES-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/lane_ptr.sv
// Round-robin lane pointer: 2-bit wrapping counter.
//   clk : clock
//   rst : asynchronous active-high reset (pointer -> 0)
//   en  : advance by one (wraps 3 -> 0)
//   clr : synchronous realign to lane 0; applied before en in the same cycle
//   ptr : current lane pointer
module lane_ptr
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [SEL_W-1:0] ptr
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;

    // clr and en together yield 1: the realigned beat consumes lane 0.
    always_comb begin
        ptr_d = clr ? '0 : ptr_q;
        if (en) begin
            ptr_d = ptr_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/demux_1_to_4.sv
// Registered 1-to-4 time-division demultiplexer with frame tracking.
//   CLK         : clock
//   RST         : asynchronous active-high reset
//   DIN         : input beat (WIDTH bits)
//   DIN_VALID   : write the beat this cycle
//   SEL         : target lane in addressed mode
//   MODE        : 0 addressed, 1 round-robin
//   SYNC        : frame realign (clears mask/overrun, pointer -> 0)
//   DOUT        : held lanes, lane k at [k*WIDTH +: WIDTH]
//   LANE_VALID  : one-hot strobe for the lane written on the previous edge
//   FRAME_VALID : one-cycle pulse when all four lanes have been written
//   OVERRUN     : sticky; a lane was rewritten before its frame completed
module demux_1_to_4
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH-1:0]           DIN,
    input  logic                       DIN_VALID,
    input  logic [SEL_W-1:0]           SEL,
    input  logic                       MODE,
    input  logic                       SYNC,
    output logic [NUM_LANES*WIDTH-1:0] DOUT,
    output logic [NUM_LANES-1:0]       LANE_VALID,
    output logic                       FRAME_VALID,
    output logic                       OVERRUN
);

    logic [NUM_LANES*WIDTH-1:0] dout_q, dout_d;
    logic [NUM_LANES-1:0]       lane_valid_q, lane_valid_d;
    logic                       frame_valid_q, frame_valid_d;
    logic                       overrun_q, overrun_d;
    logic [NUM_LANES-1:0]       mask_q, mask_d;

    logic [SEL_W-1:0]           ptr;
    logic [SEL_W-1:0]           target;
    logic [NUM_LANES-1:0]       hit;
    logic [NUM_LANES-1:0]       base_mask;
    logic [NUM_LANES-1:0]       upd_mask;
    logic                       base_overrun;
    logic                       rr_mode;

    assign rr_mode = (MODE == MODE_RR);

    lane_ptr u_lane_ptr (
        .clk (CLK),
        .rst (RST),
        .en  (DIN_VALID && rr_mode),
        .clr (SYNC),
        .ptr (ptr)
    );

    always_comb begin
        // SYNC takes effect first; a same-cycle beat sees the cleared state.
        base_mask    = SYNC ? '0 : mask_q;
        base_overrun = SYNC ? 1'b0 : overrun_q;
        target       = rr_mode ? (SYNC ? '0 : ptr) : SEL;
        hit          = lane_onehot(target);
        upd_mask     = base_mask | hit;

        dout_d        = dout_q;
        lane_valid_d  = '0;
        frame_valid_d = 1'b0;
        mask_d        = base_mask;
        overrun_d     = base_overrun;

        if (DIN_VALID) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (hit[k]) begin
                    dout_d[k*WIDTH +: WIDTH] = DIN;
                end
            end
            lane_valid_d = hit;
            if ((base_mask & hit) != '0) begin
                overrun_d = 1'b1;
            end
            if (upd_mask == FULL_MASK) begin
                frame_valid_d = 1'b1;
                mask_d        = '0;
            end else begin
                mask_d = upd_mask;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_q        <= '0;
            lane_valid_q  <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            mask_q        <= '0;
        end else begin
            dout_q        <= dout_d;
            lane_valid_q  <= lane_valid_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            mask_q        <= mask_d;
        end
    end

    assign DOUT        = dout_q;
    assign LANE_VALID  = lane_valid_q;
    assign FRAME_VALID = frame_valid_q;
    assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_demux_1_to_4.sv
// Self-checking bench for demux_1_to_4 (WIDTH = 4): directed scenarios plus a
// randomized run, all compared against a lane-array reference model.
module tb_demux_1_to_4;

    localparam int W = 4;

    logic           CLK;
    logic           RST;
    logic [W-1:0]   DIN;
    logic           DIN_VALID;
    logic [1:0]     SEL;
    logic           MODE;
    logic           SYNC;
    logic [4*W-1:0] DOUT;
    logic [3:0]     LANE_VALID;
    logic           FRAME_VALID;
    logic           OVERRUN;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: four held lanes, a per-lane "written this frame" flag,
    // an integer round-robin pointer and the expected registered strobes.
    logic [W-1:0] m_lane [4];
    bit           m_wr   [4];
    int           m_ptr;
    bit           m_ovr;
    logic [3:0]   e_lv;
    bit           e_fv;

    demux_1_to_4 #(.WIDTH(W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .DIN         (DIN),
        .DIN_VALID   (DIN_VALID),
        .SEL         (SEL),
        .MODE        (MODE),
        .SYNC        (SYNC),
        .DOUT        (DOUT),
        .LANE_VALID  (LANE_VALID),
        .FRAME_VALID (FRAME_VALID),
        .OVERRUN     (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [4*W-1:0] m_dout();
        return {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_lane[i] = '0;
            m_wr[i]   = 1'b0;
        end
        m_ptr = 0;
        m_ovr = 1'b0;
        e_lv  = '0;
        e_fv  = 1'b0;
    endtask

    // Drive one cycle, advance the model across the edge, sample at edge + 1.
    task automatic step(input bit v, input logic [1:0] s, input bit md, input bit sy,
                        input logic [W-1:0] d);
        int t;
        bit all;
        DIN_VALID = v;
        SEL       = s;
        MODE      = md;
        SYNC      = sy;
        DIN       = d;
        @(posedge CLK);
        if (sy) begin
            for (int i = 0; i < 4; i++) m_wr[i] = 1'b0;
            m_ptr = 0;
            m_ovr = 1'b0;
        end
        e_lv = '0;
        e_fv = 1'b0;
        if (v) begin
            t = md ? m_ptr : int'(s);
            if (m_wr[t]) m_ovr = 1'b1;
            m_lane[t] = d;
            m_wr[t]   = 1'b1;
            e_lv      = 4'(1 << t);
            if (md) m_ptr = (m_ptr + 1) % 4;
            all = m_wr[0] && m_wr[1] && m_wr[2] && m_wr[3];
            if (all) begin
                e_fv = 1'b1;
                for (int i = 0; i < 4; i++) m_wr[i] = 1'b0;
            end
        end
        #1;
        DIN_VALID = 1'b0;
        SYNC      = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({DOUT, LANE_VALID, FRAME_VALID, OVERRUN} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got dout=%h lv=%b fv=%b ovr=%b required all zero",
                     DOUT, LANE_VALID, FRAME_VALID, OVERRUN);
        end
        RST = 1'b0;
        model_reset();
        step(1'b0, 2'd0, 1'b1, 1'b0, '0);
        n_checks++;
        if ({DOUT, LANE_VALID, FRAME_VALID, OVERRUN} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle got dout=%h lv=%b fv=%b ovr=%b required all zero",
                     DOUT, LANE_VALID, FRAME_VALID, OVERRUN);
        end
    endtask

    task automatic test_rr_frame();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'($urandom), 1'b1, 1'b0, 4'(4'hA + i));
            n_checks++;
            if (LANE_VALID !== 4'(1 << i) || FRAME_VALID !== (i == 3)) begin
                n_fail++;
                $display("FAIL rr_strobe beat %0d got lv=%b fv=%b required lv=%b fv=%b",
                         i, LANE_VALID, FRAME_VALID, 4'(1 << i), (i == 3));
            end
        end
        n_checks++;
        if (DOUT !== 16'hDCBA || OVERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_dout got dout=%h ovr=%b required dout=dcba ovr=0", DOUT, OVERRUN);
        end
    endtask

    task automatic test_addressed();
        logic [1:0] sels [4];
        sels = '{2'd3, 2'd1, 2'd0, 2'd2};
        step(1'b0, 2'd0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, sels[i], 1'b0, 1'b0, 4'(i + 1));
            n_checks++;
            if (LANE_VALID !== e_lv || FRAME_VALID !== (i == 3)) begin
                n_fail++;
                $display("FAIL addr_strobe beat %0d got lv=%b fv=%b required lv=%b fv=%b",
                         i, LANE_VALID, FRAME_VALID, e_lv, (i == 3));
            end
        end
        n_checks++;
        if (DOUT !== 16'h1423) begin
            n_fail++;
            $display("FAIL addr_dout got %h required 1423", DOUT);
        end
    endtask

    task automatic test_overrun();
        step(1'b0, 2'd0, 1'b0, 1'b1, '0);
        step(1'b1, 2'd2, 1'b0, 1'b0, 4'h5);
        n_checks++;
        if (OVERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_first got %b required 0", OVERRUN);
        end
        step(1'b1, 2'd2, 1'b0, 1'b0, 4'h6);
        n_checks++;
        if (OVERRUN !== 1'b1 || DOUT[11:8] !== 4'h6 || LANE_VALID !== 4'b0100) begin
            n_fail++;
            $display("FAIL ovr_second got ovr=%b lane2=%h lv=%b required ovr=1 lane2=6 lv=0100",
                     OVERRUN, DOUT[11:8], LANE_VALID);
        end
        step(1'b0, 2'd0, 1'b0, 1'b0, '0);
        step(1'b1, 2'd0, 1'b0, 1'b0, 4'h7);
        n_checks++;
        if (OVERRUN !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky got %b required 1", OVERRUN);
        end
        step(1'b0, 2'd0, 1'b0, 1'b1, '0);
        n_checks++;
        if (OVERRUN !== 1'b0 || DOUT !== m_dout()) begin
            n_fail++;
            $display("FAIL ovr_sync_clear got ovr=%b dout=%h required ovr=0 dout=%h",
                     OVERRUN, DOUT, m_dout());
        end
    endtask

    task automatic test_sync_mid();
        step(1'b0, 2'd0, 1'b1, 1'b1, '0);
        step(1'b1, 2'd0, 1'b1, 1'b0, 4'h1);
        step(1'b1, 2'd0, 1'b1, 1'b0, 4'h2);
        step(1'b1, 2'd3, 1'b1, 1'b1, 4'h5);
        n_checks++;
        if (LANE_VALID !== 4'b0001 || DOUT[3:0] !== 4'h5 || FRAME_VALID !== 1'b0
            || OVERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_beat got lv=%b lane0=%h fv=%b ovr=%b required 0001 5 0 0",
                     LANE_VALID, DOUT[3:0], FRAME_VALID, OVERRUN);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'd0, 1'b1, 1'b0, 4'(8 + i));
            n_checks++;
            if (FRAME_VALID !== (i == 2) || LANE_VALID !== 4'(2 << i)) begin
                n_fail++;
                $display("FAIL sync_follow beat %0d got fv=%b lv=%b required fv=%b lv=%b",
                         i, FRAME_VALID, LANE_VALID, (i == 2), 4'(2 << i));
            end
        end
    endtask

    task automatic test_gapped();
        bit pat [7];
        int nvalid;
        logic [4*W-1:0] prev;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        nvalid = 0;
        step(1'b0, 2'd0, 1'b1, 1'b1, '0);
        for (int i = 0; i < 7; i++) begin
            prev = DOUT;
            step(pat[i], 2'($urandom), 1'b1, 1'b0, 4'($urandom));
            if (pat[i]) nvalid++;
            n_checks++;
            if ((!pat[i] && DOUT !== prev) || DOUT !== m_dout()
                || FRAME_VALID !== (pat[i] && nvalid == 4) || LANE_VALID !== e_lv) begin
                n_fail++;
                $display("FAIL gapped cyc %0d got dout=%h fv=%b lv=%b required dout=%h fv=%b lv=%b",
                         i, DOUT, FRAME_VALID, LANE_VALID, m_dout(),
                         (pat[i] && nvalid == 4), e_lv);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 2'd0, 1'b1, 1'b1, '0);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 1'b1, 1'b0, 4'hF);
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if ({DOUT, LANE_VALID, FRAME_VALID, OVERRUN} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got dout=%h lv=%b fv=%b ovr=%b required all zero",
                     DOUT, LANE_VALID, FRAME_VALID, OVERRUN);
        end
        #2;
        RST = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'd3, 1'b1, 1'b0, 4'(i + 3));
            n_checks++;
            if (LANE_VALID !== 4'(1 << i) || FRAME_VALID !== (i == 3) || DOUT !== m_dout()) begin
                n_fail++;
                $display("FAIL post_reset beat %0d got lv=%b fv=%b dout=%h required %b %b %h",
                         i, LANE_VALID, FRAME_VALID, DOUT, 4'(1 << i), (i == 3), m_dout());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7), 2'($urandom), 1'($urandom),
                 ($urandom_range(0, 19) == 0), 4'($urandom));
            n_checks++;
            if (DOUT !== m_dout() || LANE_VALID !== e_lv || FRAME_VALID !== e_fv
                || OVERRUN !== m_ovr) begin
                n_fail++;
                $display("FAIL random cyc %0d got dout=%h lv=%b fv=%b ovr=%b required %h %b %b %b",
                         i, DOUT, LANE_VALID, FRAME_VALID, OVERRUN, m_dout(), e_lv, e_fv, m_ovr);
            end
        end
    endtask

    initial begin
        RST       = 1'b1;
        DIN       = '0;
        DIN_VALID = 1'b0;
        SEL       = '0;
        MODE      = 1'b0;
        SYNC      = 1'b0;
        model_reset();
        #10;
        test_reset();
        test_rr_frame();
        test_addressed();
        test_overrun();
        test_sync_mid();
        test_gapped();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
